// File: rtl/sort_topk_collector.sv
`default_nettype none
// ============================================================================
// Module   : sort_topk_collector
// Summary  : Captures NUM sorted (value, index) beats and drains the first
//            TOPK of them over a valid/ready stream.
//            Optional macro SORT_ORDER_CHECK_EN adds an ascending-order monitor.
// Revision : 1.0  initial release
// ============================================================================
module sort_topk_collector #(
    parameter int LENGTH = 32,
    parameter int WIDTH  = 16,
    parameter int NUM    = 8,
    parameter int TOPK   = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LENGTH-1:0] in_data,
    input  logic [WIDTH-1:0]  in_index,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data,
    output logic [WIDTH-1:0]  out_index,
    output logic [CNT_W-1:0]  out_rank,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              order_err
);

    localparam int               c_AW        = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] c_NUM_LAST  = CNT_W'(NUM - 1);
    localparam logic [CNT_W-1:0] c_TOPK_LAST = CNT_W'(TOPK - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LENGTH-1:0] r_buf_data  [NUM];
    logic [WIDTH-1:0]  r_buf_index [NUM];

    logic [CNT_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  w_rd_next;
    logic [LENGTH-1:0] r_out_data;
    logic [WIDTH-1:0]  r_out_index;
    logic              r_overflow;

    logic w_accept;
    logic w_last_beat;
    logic w_handshake;
    logic w_last_out;

    assign in_ready    = (r_state == S_IDLE) || (r_state == S_CAPTURE);
    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = w_accept && (r_state == S_CAPTURE) && (r_wr_ptr == c_NUM_LAST);
    assign out_valid   = (r_state == S_DRAIN);
    assign w_handshake = out_valid && out_ready;
    assign w_last_out  = (r_rd_ptr == c_TOPK_LAST);
    assign w_rd_next   = r_rd_ptr + CNT_W'(1);

    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_rank  = r_rd_ptr;
    assign out_last  = out_valid && w_last_out;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (w_last_beat) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_handshake && w_last_out) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Frame storage carries no reset: contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_data[r_wr_ptr[c_AW-1:0]]  <= in_data;
            r_buf_index[r_wr_ptr[c_AW-1:0]] <= in_index;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end else if (w_accept && (r_state == S_IDLE)) begin
                r_overflow <= 1'b0;
            end

            if (w_accept) begin
                r_wr_ptr <= w_last_beat ? '0 : r_wr_ptr + CNT_W'(1);
            end

            // Entry 0 was written on an earlier beat, so rank 0 can be
            // presented in the cycle right after the final beat lands.
            if (w_last_beat) begin
                r_rd_ptr    <= '0;
                r_out_data  <= r_buf_data[0];
                r_out_index <= r_buf_index[0];
            end else if (w_handshake && !w_last_out) begin
                r_rd_ptr    <= w_rd_next;
                r_out_data  <= r_buf_data[w_rd_next[c_AW-1:0]];
                r_out_index <= r_buf_index[w_rd_next[c_AW-1:0]];
            end else if (r_state == S_DONE) begin
                r_rd_ptr <= '0;
            end
        end
    end

`ifdef SORT_ORDER_CHECK_EN
    logic [LENGTH-1:0] r_prev_data;
    logic              r_order_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_data <= '0;
            r_order_err <= 1'b0;
        end else if (w_accept) begin
            r_prev_data <= in_data;
            if (r_state == S_IDLE) begin
                r_order_err <= 1'b0;
            end else if (in_data < r_prev_data) begin
                r_order_err <= 1'b1;
            end
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_topk_collector.sv
`default_nettype none
// Directed self-checking bench for sort_topk_collector (TOPK=4 and TOPK=NUM=8 instances).
module tb_sort_topk_collector;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, done, overflow, order_err;
    logic [31:0] in_data, out_data;
    logic [15:0] in_index, out_index;
    logic [7:0]  out_rank;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2, done2, overflow2, order_err2;
    logic [31:0] in_data2, out_data2;
    logic [15:0] in_index2, out_index2;
    logic [7:0]  out_rank2;

    sort_topk_collector #(.LENGTH(32), .WIDTH(16), .NUM(8), .TOPK(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_index(in_index), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_rank(out_rank), .out_last(out_last), .busy(busy), .done(done),
        .overflow(overflow), .order_err(order_err)
    );

    sort_topk_collector #(.LENGTH(32), .WIDTH(16), .NUM(8), .TOPK(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_data(in_data2), .in_index(in_index2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_index(out_index2),
        .out_rank(out_rank2), .out_last(out_last2), .busy(busy2), .done(done2),
        .overflow(overflow2), .order_err(order_err2)
    );

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] fa_d [8] = '{32'd0, 32'd8, 32'd8, 32'd64, 32'd77, 32'd148, 32'd981, 32'd1024};
    logic [15:0] fa_i [8] = '{16'd0, 16'd1, 16'd6, 16'd4, 16'd7, 16'd2, 16'd3, 16'd5};
    logic [31:0] fb_d [8] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
    logic [15:0] fb_i [8] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd7, 16'd6, 16'd5, 16'd4};

    // Drives beats [first,last) of frame sel on consecutive cycles.
    task automatic send_beats(input int sel, input int first, input int last);
        for (int i = first; i < last; i++) begin
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL capture_out_valid beat%0d: got %b want 0", i, out_valid);
            end
            in_valid = 1'b1;
            in_data  = (sel == 1) ? fb_d[i] : fa_d[i];
            in_index = (sel == 1) ? fb_i[i] : fa_i[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Drains 4 entries of frame sel, optionally toggling out_ready each cycle.
    task automatic drain(input int sel, input bit toggle, input string tag);
        int k;
        int cyc;
        logic [31:0] ed;
        logic [15:0] ei;
        k   = 0;
        cyc = 0;
        out_ready = toggle ? 1'b0 : 1'b1;
        while (k < 4 && cyc < 40) begin
            ed = (sel == 1) ? fb_d[k] : fa_d[k];
            ei = (sel == 1) ? fb_i[k] : fa_i[k];
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== ed || out_index !== ei ||
                out_rank !== 8'(k) || out_last !== (k == 3)) begin
                n_err++;
                $display("FAIL %s rank%0d: got v=%b %0d/%0d r%0d last=%b want v=1 %0d/%0d r%0d last=%b",
                         tag, k, out_valid, out_data, out_index, out_rank, out_last, ed, ei, k, (k == 3));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) k++;
            @(negedge clk);
            cyc++;
            if (toggle) out_ready = ~out_ready;
        end
        n_chk++;
        if (k != 4) begin
            n_err++;
            $display("FAIL %s handshakes: got %0d want 4", tag, k);
        end
        n_chk++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s done_cycle: got done=%b valid=%b busy=%b want 1 0 1", tag, done, out_valid, busy);
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s idle_after: got done=%b busy=%b in_ready=%b want 0 0 1", tag, done, busy, in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 || out_index !== 16'd0 ||
            out_rank !== 8'd0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            overflow !== 1'b0 || order_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b v=%b d=%0d i=%0d r=%0d l=%b b=%b dn=%b ov=%b oe=%b want 1 0 0 0 0 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_index, out_rank, out_last, busy, done, overflow, order_err);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_beats(0, 0, 8);
        drain(0, 1'b0, "basic");
    endtask

    task automatic test_stall();
        send_beats(0, 0, 8);
        drain(0, 1'b1, "stall");
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_beats(0, 0, 8);
        in_valid = 1'b1;
        in_data  = 32'd999;
        in_index = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (in_ready !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag: got in_ready=%b overflow=%b want 0 1", in_ready, overflow);
        end
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || out_index !== 16'd0 || out_rank !== 8'd0) begin
            n_err++;
            $display("FAIL ovf_hold: got v=%b %0d/%0d r%0d want 1 0/0 r0", out_valid, out_data, out_index, out_rank);
        end
        drain(0, 1'b0, "ovf_drain");
        n_chk++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        send_beats(1, 0, 1);
        n_chk++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        send_beats(1, 1, 8);
        drain(1, 1'b0, "frame_b");
    endtask

    task automatic test_reset_mid();
        send_beats(0, 0, 5);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
            out_index !== 16'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_values: got rdy=%b busy=%b v=%b d=%0d i=%0d ov=%b want 1 0 0 0 0 0",
                     in_ready, busy, out_valid, out_data, out_index, overflow);
        end
        rst = 1'b1;
        @(negedge clk);
        send_beats(1, 0, 8);
        drain(1, 1'b0, "midreset_drain");
    endtask

    task automatic test_topk_all();
        int k;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            in_valid2 = 1'b1;
            in_data2  = fa_d[i];
            in_index2 = fa_i[i];
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 30) begin
            n_chk++;
            if (out_valid2 !== 1'b1 || out_data2 !== fa_d[k] || out_index2 !== fa_i[k] ||
                out_rank2 !== 8'(k) || out_last2 !== (k == 7)) begin
                n_err++;
                $display("FAIL topk8 rank%0d: got v=%b %0d/%0d r%0d last=%b want v=1 %0d/%0d r%0d last=%b",
                         k, out_valid2, out_data2, out_index2, out_rank2, out_last2, fa_d[k], fa_i[k], k, (k == 7));
            end
            if (out_valid2 === 1'b1) k++;
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (k != 8 || done2 !== 1'b1) begin
            n_err++;
            $display("FAIL topk8_done: got handshakes=%0d done=%b want 8 1", k, done2);
        end
        @(negedge clk);
    endtask

    task automatic test_order();
        logic exp_oe;
`ifdef SORT_ORDER_CHECK_EN
        exp_oe = 1'b1;
`else
        exp_oe = 1'b0;
`endif
        in_valid = 1'b1;
        in_data  = 32'd5;
        in_index = 16'd0;
        @(negedge clk);
        n_chk++;
        if (order_err !== 1'b0) begin
            n_err++;
            $display("FAIL order_first: got %b want 0", order_err);
        end
        in_data  = 32'd3;
        in_index = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (order_err !== exp_oe) begin
            n_err++;
            $display("FAIL order_err: got %b want %b", order_err, exp_oe);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_index   = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_index2  = '0;
        out_ready2 = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_topk_all();
        test_order();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
